// File: rtl/serial_paralelo_pkg.sv
// Purpose: shared PHY lane constants and FSM encoding for the receive deserializer.
//          COMMA is the same idle/alignment symbol paralelo_serial transmits.
// Contents: COMMA symbol, datapath widths, state_t encoding, comma compare helper.
package serial_paralelo_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned BC_CNT_W = 4;

    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [BYTE_W-1:0] i_byte);
        return i_byte == COMMA;
    endfunction

endpackage

// File: rtl/serial_paralelo_if.sv
// Purpose: lane bus between the serial bit source and the deserializer.
// Signals: data_in   - serial bit, MSB of each byte first
//          data_out  - last received data byte
//          valid_out - one-cycle strobe, data_out holds a new byte
//          active    - lane aligned and locked
// Modports: master drives the serial bit and observes results; slave is the deserializer.
interface serial_paralelo_if;
    import serial_paralelo_pkg::*;

    logic              data_in;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    logic              active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

endinterface

// File: rtl/serial_paralelo_shift.sv
// Purpose: serial-in shift register plus the 3-bit byte-boundary counter.
// Ports: clk_32f, reset       - bit clock, async active-high reset
//        i_data_in            - serial bit sampled every rising edge
//        i_cnt_clear          - forces the boundary counter to 0 at this edge
//        o_nxt_c              - byte completed by the bit sampled at this edge
//        o_cnt                - current boundary counter value
//        o_boundary_c         - this edge completes an aligned byte (cnt == 7)
module serial_paralelo_shift
    import serial_paralelo_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              i_data_in,
    input  logic              i_cnt_clear,
    output logic [BYTE_W-1:0] o_nxt_c,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_boundary_c
);

    logic [BYTE_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;

    assign o_nxt_c      = {r_sr[BYTE_W-2:0], i_data_in};
    assign o_cnt        = r_cnt;
    assign o_boundary_c = (r_cnt == CNT_W'(BYTE_W - 1));

    // Shift register and free-running wrap counter.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            r_sr <= o_nxt_c;
            if (i_cnt_clear) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/serial_paralelo.sv
// Purpose: lane deserializer. Locks byte alignment after COMMA_COUNT consecutive
//          aligned COMMA symbols, then strobes out every non-COMMA byte.
// Ports: clk_32f - serial bit clock
//        reset   - async active-high reset
//        bus     - serial_paralelo_if.slave (data_in in; data_out/valid_out/active out)
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter int unsigned COMMA_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    serial_paralelo_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BC_CNT_W-1:0] r_bc_cnt;
    logic [BC_CNT_W-1:0] w_bc_cnt_nxt;
    logic [BYTE_W-1:0]   r_data_out;
    logic [BYTE_W-1:0]   w_data_out_nxt;
    logic                r_valid_out;
    logic                w_valid_out_nxt;
    logic                r_active;
    logic                w_active_nxt;

    logic [BYTE_W-1:0]   w_nxt;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_boundary;
    logic                w_cnt_clear;
    logic                w_comma;
    logic                w_lock_hit;

    serial_paralelo_shift u_shift (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .i_data_in    (bus.data_in),
        .i_cnt_clear  (w_cnt_clear),
        .o_nxt_c      (w_nxt),
        .o_cnt        (w_cnt),
        .o_boundary_c (w_boundary)
    );

    assign w_comma    = is_comma(w_nxt);
    // This aligned comma completes the required run.
    assign w_lock_hit = (BC_CNT_W'(r_bc_cnt + BC_CNT_W'(1)) == BC_CNT_W'(COMMA_COUNT));

    // State and output registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_bc_cnt    <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bc_cnt    <= w_bc_cnt_nxt;
            r_data_out  <= w_data_out_nxt;
            r_valid_out <= w_valid_out_nxt;
            r_active    <= w_active_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEARCH: begin
                if (w_comma) begin
                    w_state_nxt = (COMMA_COUNT == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (!w_comma) begin
                        w_state_nxt = SEARCH;
                    end else if (w_lock_hit) begin
                        w_state_nxt = ACTIVE;
                    end
                end
            end
            ACTIVE: w_state_nxt = ACTIVE;
            default: w_state_nxt = SEARCH;
        endcase
    end

    // Next values for the output registers, comma counter and counter clear.
    always_comb begin
        w_bc_cnt_nxt    = r_bc_cnt;
        w_data_out_nxt  = r_data_out;
        w_valid_out_nxt = 1'b0;
        w_active_nxt    = r_active;
        w_cnt_clear     = 1'b0;
        case (r_state)
            SEARCH: begin
                // Counter held at 0 so a comma hit fixes the byte boundary here.
                w_cnt_clear = 1'b1;
                if (w_comma) begin
                    w_bc_cnt_nxt = BC_CNT_W'(1);
                    if (COMMA_COUNT == 1) begin
                        w_active_nxt = 1'b1;
                    end
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (w_comma) begin
                        w_bc_cnt_nxt = BC_CNT_W'(r_bc_cnt + BC_CNT_W'(1));
                        if (w_lock_hit) begin
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_bc_cnt_nxt = '0;
                    end
                end
            end
            ACTIVE: begin
                if (w_boundary && !w_comma) begin
                    w_data_out_nxt  = w_nxt;
                    w_valid_out_nxt = 1'b1;
                end
            end
            default: begin
                w_bc_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.active    = r_active;

    // Boundary flag and exposed counter must agree.
    a_boundary_cnt: assert property (@(posedge clk_32f) disable iff (reset)
        w_boundary == (w_cnt == CNT_W'(BYTE_W - 1)));

endmodule

// File: tb/tb_serial_paralelo.sv
// Purpose: self-checking bench for serial_paralelo. Expected bytes are queued as
//          they are driven and compared whenever the DUT strobes valid_out.
module tb_serial_paralelo;
    import serial_paralelo_pkg::*;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int prev_cyc = 0;

    logic [7:0] exp_q[$];

    serial_paralelo_if u_if ();

    serial_paralelo #(.COMMA_COUNT(4)) u_dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (u_if.slave)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one bit, step past the edge that samples it, score any valid strobe.
    task automatic send_bit(input logic b);
        u_if.data_in = b;
        @(posedge clk_32f);
        #1;
        cyc++;
        if (u_if.valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("valid_unexpected", 32'(u_if.valid_out), 32'd0);
            end else begin
                check("data_out", 32'(u_if.data_out), 32'(exp_q.pop_front()));
                prev_cyc = last_cyc;
                last_cyc = cyc;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic expect_out);
        if (expect_out) exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Transmitter model: idle lane carries COMMA, valid bytes go out MSB first.
    task automatic tx_byte(input logic valid_in, input logic [7:0] b);
        if (valid_in) send_byte(b, 1'b1);
        else          send_byte(COMMA, 1'b0);
    endtask

    task automatic do_reset();
        u_if.data_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk_32f);
        #3 reset = 1'b0;
        @(posedge clk_32f);
        #1;
        exp_q.delete();
    endtask

    task automatic check_drained(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        u_if.data_in = 1'b0;

        // Test 1: bit-aligned lock then a single data byte.
        do_reset();
        check("rst_active",   32'(u_if.active),    32'd0);
        check("rst_valid",    32'(u_if.valid_out), 32'd0);
        check("rst_data_out", 32'(u_if.data_out),  32'h00);
        for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
        check("t1_active_3bc", 32'(u_if.active), 32'd0);
        send_byte(COMMA, 1'b0);
        check("t1_active_4bc", 32'(u_if.active), 32'd1);
        check("t1_data_pre",   32'(u_if.data_out), 32'h00);
        send_byte(8'h55, 1'b1);
        send_bit(1'b0);
        check("t1_valid_once", 32'(u_if.valid_out), 32'd0);
        check_drained("t1_drained");

        // Test 2: three garbage bits shift the byte boundary.
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(COMMA, 1'b0);
        check("t2_active", 32'(u_if.active), 32'd1);
        send_byte(8'hA7, 1'b1);
        check("t2_data_out", 32'(u_if.data_out), 32'hA7);
        check_drained("t2_drained");

        // Test 3: broken comma run returns to search, then relocks.
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
        check("t3_active_3bc", 32'(u_if.active), 32'd0);
        send_byte(8'h00, 1'b0);
        check("t3_active_break", 32'(u_if.active), 32'd0);
        for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
        check("t3_active_relock_3", 32'(u_if.active), 32'd0);
        send_byte(COMMA, 1'b0);
        check("t3_active_relock_4", 32'(u_if.active), 32'd1);
        send_byte(8'h3C, 1'b1);
        check("t3_data_out", 32'(u_if.data_out), 32'h3C);
        check_drained("t3_drained");

        // Test 4: idle commas interleaved with data while active.
        send_byte(8'h11, 1'b1);
        send_byte(COMMA, 1'b0);
        check("t4_hold_bc1", 32'(u_if.data_out), 32'h11);
        send_byte(COMMA, 1'b0);
        check("t4_hold_bc2", 32'(u_if.data_out), 32'h11);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check("t4_pulse_gap", 32'(last_cyc - prev_cyc), 32'd8);
        check("t4_data_out", 32'(u_if.data_out), 32'h33);
        check_drained("t4_drained");

        // Test 5: asynchronous reset mid-cycle while active.
        #2 reset = 1'b1;
        #1;
        check("t5_async_active", 32'(u_if.active),    32'd0);
        check("t5_async_data",   32'(u_if.data_out),  32'h00);
        check("t5_async_valid",  32'(u_if.valid_out), 32'd0);
        @(posedge clk_32f);
        u_if.data_in = 1'b0;
        #3 reset = 1'b0;
        @(posedge clk_32f);
        #1;
        for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
        check("t5_active_3bc", 32'(u_if.active), 32'd0);
        send_byte(COMMA, 1'b0);
        check("t5_active_4bc", 32'(u_if.active), 32'd1);

        // Test 6: transmitter model idles, then sends a short byte stream.
        do_reset();
        for (int i = 0; i < 6; i++) tx_byte(1'b0, 8'h00);
        check("t6_active", 32'(u_if.active), 32'd1);
        tx_byte(1'b1, 8'hFF);
        tx_byte(1'b1, 8'h00);
        tx_byte(1'b1, 8'h5A);
        tx_byte(1'b0, 8'h00);
        tx_byte(1'b0, 8'h00);
        check("t6_last_data", 32'(u_if.data_out), 32'h5A);
        check_drained("t6_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
